dmi_jtag_dr_ctrl: RTL and testbench

- Sequences the DTMCS and DMI data registers behind the JTAG TAP.
- Owns the DR shift registers and the DMI transaction state machine, and issues DMI requests on a valid/ready handshake.
- Reports busy and failed status to the debugger through sticky error bits.
- Runs entirely in the TCK domain. The CDC to the debug module is a separate downstream block.

---
 rtl/dmi_jtag_dr_ctrl_pkg.sv | 50 +++++
 rtl/dmi_jtag_dr_ctrl.sv | 144 ++++++++++++++
 tb/tb_dmi_jtag_dr_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/dmi_jtag_dr_ctrl_pkg.sv
// Shared DTM types: DMI op and status encodings, DTMCS layout, DMI request/response
// records and the DR controller transaction states.
package dmi_jtag_dr_ctrl_pkg;

  typedef enum logic [1:0] {
    DtmNop      = 2'd0,
    DtmRead     = 2'd1,
    DtmWrite    = 2'd2,
    DtmReserved = 2'd3
  } dtm_op_e;

  typedef enum logic [1:0] {
    DmiNoError  = 2'd0,
    DmiOpFailed = 2'd2,
    DmiBusy     = 2'd3
  } dmi_error_e;

  typedef struct packed {
    logic [13:0] zero1;
    logic        dmihardreset;
    logic        dmireset;
    logic        zero0;
    logic [2:0]  idle;
    logic [1:0]  dmistat;
    logic [5:0]  abits;
    logic [3:0]  version;
  } dtmcs_t;

  localparam int unsigned DmiAddrMaxW = 32;

  typedef struct packed {
    logic [DmiAddrMaxW-1:0] addr;
    logic [31:0]            data;
    dtm_op_e                op;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

  typedef enum logic [2:0] {
    Idle,
    Read,
    WaitRead,
    Write,
    WaitWrite
  } dmi_state_e;

endpackage

// File: rtl/dmi_jtag_dr_ctrl.sv
// DTMCS / DMIACCESS data-register sequencing and DMI request FSM, all in the TCK domain.
// Errors are sticky: only dmireset, dmihardreset, TAP reset or trst_ni clear them.
module dmi_jtag_dr_ctrl #(
  parameter int unsigned AbitsW     = 7,
  parameter int unsigned IdleCycles = 1,
  parameter int unsigned DtmVersion = 1
) (
  input  logic              tck_i,
  input  logic              trst_ni,
  input  logic              dmi_clear_i,
  input  logic              capture_i,
  input  logic              shift_i,
  input  logic              update_i,
  input  logic              tdi_i,
  input  logic              dtmcs_select_i,
  input  logic              dmi_select_i,
  output logic              dtmcs_tdo_o,
  output logic              dmi_tdo_o,
  output logic              dmi_req_valid_o,
  input  logic              dmi_req_ready_i,
  output logic [1:0]        dmi_req_op_o,
  output logic [AbitsW-1:0] dmi_req_addr_o,
  output logic [31:0]       dmi_req_data_o,
  input  logic              dmi_resp_valid_i,
  output logic              dmi_resp_ready_o,
  input  logic [31:0]       dmi_resp_data_i,
  input  logic [1:0]        dmi_resp_op_i,
  output logic              dmi_rst_no
);
  import dmi_jtag_dr_ctrl_pkg::*;

  localparam int unsigned DmiW = AbitsW + 34;

  logic [31:0]       dtmcs_q;
  logic [DmiW-1:0]   dmi_q;
  dmi_state_e        state_q, state_d;
  dmi_error_e        error_q, error_d;
  logic [AbitsW-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              rst_n_q;

  dtmcs_t  dtmcs_cap;
  dtm_op_e scan_op;
  logic    dtmcs_update, dmireset, hardreset, clear;
  logic    dmi_capture, dmi_update, busy_access, resp_err;
  logic    unused_dtmcs;

  assign dtmcs_update = update_i & dtmcs_select_i;
  assign dmireset     = dtmcs_update & dtmcs_q[16];
  assign hardreset    = dtmcs_update & dtmcs_q[17];
  assign clear        = hardreset | dmi_clear_i;
  assign dmi_capture  = capture_i & dmi_select_i;
  assign dmi_update   = update_i & dmi_select_i;
  assign busy_access  = (dmi_capture | dmi_update) & (state_q != Idle);
  assign scan_op      = dtm_op_e'(dmi_q[1:0]);
  assign unused_dtmcs = ^{dtmcs_q[31:18], dtmcs_q[15:1]};

  always_comb begin
    dtmcs_cap         = '0;
    dtmcs_cap.idle    = 3'(IdleCycles);
    dtmcs_cap.dmistat = error_q;
    dtmcs_cap.abits   = 6'(AbitsW);
    dtmcs_cap.version = 4'(DtmVersion);
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    resp_err = 1'b0;
    case (state_q)
      Idle: begin
        if (dmi_update && (error_q == DmiNoError) &&
            ((scan_op == DtmRead) || (scan_op == DtmWrite))) begin
          addr_d  = dmi_q[DmiW-1:34];
          data_d  = dmi_q[33:2];
          state_d = (scan_op == DtmRead) ? Read : Write;
        end
      end
      Read:  if (dmi_req_ready_i) state_d = WaitRead;
      Write: if (dmi_req_ready_i) state_d = WaitWrite;
      WaitRead: begin
        if (dmi_resp_valid_i) begin
          state_d  = Idle;
          data_d   = dmi_resp_data_i;
          resp_err = (dmi_resp_op_i != 2'd0);
        end
      end
      WaitWrite: begin
        if (dmi_resp_valid_i) begin
          state_d  = Idle;
          resp_err = (dmi_resp_op_i != 2'd0);
        end
      end
      default: state_d = Idle;
    endcase
    // Hard reset / TAP reset abandon any transaction, even one accepted this cycle.
    if (clear) state_d = Idle;
  end

  // Busy outranks a failing response that lands in the same cycle.
  always_comb begin
    error_d = error_q;
    if (clear || dmireset) begin
      error_d = DmiNoError;
    end else if (error_q == DmiNoError) begin
      if (busy_access)   error_d = DmiBusy;
      else if (resp_err) error_d = DmiOpFailed;
    end
  end

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      state_q <= Idle;
      error_q <= DmiNoError;
      addr_q  <= '0;
      data_q  <= '0;
      dtmcs_q <= '0;
      dmi_q   <= '0;
      rst_n_q <= 1'b1;
    end else begin
      state_q <= state_d;
      error_q <= error_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rst_n_q <= ~hardreset;
      if (capture_i && dtmcs_select_i)    dtmcs_q <= dtmcs_cap;
      else if (shift_i && dtmcs_select_i) dtmcs_q <= {tdi_i, dtmcs_q[31:1]};
      if (dmi_capture)                    dmi_q <= {addr_q, data_q, error_q};
      else if (shift_i && dmi_select_i)   dmi_q <= {tdi_i, dmi_q[DmiW-1:1]};
    end
  end

  assign dtmcs_tdo_o      = dtmcs_q[0];
  assign dmi_tdo_o        = dmi_q[0];
  assign dmi_req_valid_o  = (state_q == Read) || (state_q == Write);
  assign dmi_req_op_o     = (state_q == Read)  ? DtmRead  :
                            (state_q == Write) ? DtmWrite : DtmNop;
  assign dmi_req_addr_o   = addr_q;
  assign dmi_req_data_o   = data_q;
  assign dmi_resp_ready_o = (state_q == WaitRead) || (state_q == WaitWrite);
  assign dmi_rst_no       = rst_n_q;

endmodule

// File: tb/tb_dmi_jtag_dr_ctrl.sv
// Directed bench for the DTMCS/DMI DR controller: scans drive both DRs LSB first and
// every observation is compared with hand-derived values.
module tb_dmi_jtag_dr_ctrl;

  logic        tck, trst_n, dmi_clear, capture, shift, update, tdi;
  logic        dtmcs_sel, dmi_sel, dtmcs_tdo, dmi_tdo;
  logic        req_valid, req_ready, resp_valid, resp_ready, rst_n_out;
  logic [1:0]  req_op, resp_op;
  logic [6:0]  req_addr;
  logic [31:0] req_data, resp_data;

  int n_cmp = 0;
  int n_mis = 0;
  int n_acc = 0;

  logic [31:0] dt_out;
  logic [40:0] dm_out;
  int          acc0;

  dmi_jtag_dr_ctrl #(.AbitsW(7), .IdleCycles(1), .DtmVersion(1)) dut (
    .tck_i(tck), .trst_ni(trst_n), .dmi_clear_i(dmi_clear),
    .capture_i(capture), .shift_i(shift), .update_i(update), .tdi_i(tdi),
    .dtmcs_select_i(dtmcs_sel), .dmi_select_i(dmi_sel),
    .dtmcs_tdo_o(dtmcs_tdo), .dmi_tdo_o(dmi_tdo),
    .dmi_req_valid_o(req_valid), .dmi_req_ready_i(req_ready),
    .dmi_req_op_o(req_op), .dmi_req_addr_o(req_addr), .dmi_req_data_o(req_data),
    .dmi_resp_valid_i(resp_valid), .dmi_resp_ready_o(resp_ready),
    .dmi_resp_data_i(resp_data), .dmi_resp_op_i(resp_op),
    .dmi_rst_no(rst_n_out)
  );

  initial tck = 1'b0;
  always #5 tck = ~tck;

  always @(posedge tck) if (req_valid && req_ready) n_acc++;

  task automatic clk_step();
    @(posedge tck);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic scan_dtmcs(input logic [31:0] din, output logic [31:0] dout);
    dtmcs_sel = 1'b1; capture = 1'b1; clk_step();
    capture = 1'b0; shift = 1'b1;
    for (int i = 0; i < 32; i++) begin
      tdi = din[i]; dout[i] = dtmcs_tdo; clk_step();
    end
    shift = 1'b0; update = 1'b1; clk_step();
    update = 1'b0; dtmcs_sel = 1'b0; tdi = 1'b0;
  endtask

  task automatic scan_dmi(input logic [40:0] din, output logic [40:0] dout);
    dmi_sel = 1'b1; capture = 1'b1; clk_step();
    capture = 1'b0; shift = 1'b1;
    for (int i = 0; i < 41; i++) begin
      tdi = din[i]; dout[i] = dmi_tdo; clk_step();
    end
    shift = 1'b0; update = 1'b1; clk_step();
    update = 1'b0; dmi_sel = 1'b0; tdi = 1'b0;
  endtask

  task automatic accept();
    req_ready = 1'b1; clk_step(); req_ready = 1'b0;
  endtask

  task automatic respond(input logic [31:0] d, input logic [1:0] op);
    resp_valid = 1'b1; resp_data = d; resp_op = op; clk_step();
    resp_valid = 1'b0; resp_data = '0; resp_op = 2'd0;
  endtask

  initial begin
    trst_n = 1'b0; dmi_clear = 1'b0; capture = 1'b0; shift = 1'b0; update = 1'b0;
    tdi = 1'b0; dtmcs_sel = 1'b0; dmi_sel = 1'b0; req_ready = 1'b0;
    resp_valid = 1'b0; resp_data = '0; resp_op = 2'd0;
    clk_step(); clk_step();

    // Reset values
    check("rst_valid", req_valid, 1'b0);
    check("rst_op", req_op, 2'd0);
    check("rst_addr", req_addr, 7'd0);
    check("rst_data", req_data, 32'd0);
    check("rst_resp_ready", resp_ready, 1'b0);
    check("rst_tdo", {dtmcs_tdo, dmi_tdo}, 2'b00);
    check("rst_dmi_rst_n", rst_n_out, 1'b1);
    trst_n = 1'b1; clk_step();
    scan_dtmcs(32'h0, dt_out);
    check("dtmcs_default", dt_out, 32'h0000_1071);

    // Read
    scan_dmi({7'h10, 32'h0, 2'd1}, dm_out);
    check("rd_valid", req_valid, 1'b1);
    check("rd_op", req_op, 2'd1);
    check("rd_addr", req_addr, 7'h10);
    acc0 = n_acc;
    accept();
    check("rd_valid_drop", req_valid, 1'b0);
    check("rd_resp_ready", resp_ready, 1'b1);
    check("rd_one_accept", n_acc, acc0 + 1);
    respond(32'hDEAD_BEEF, 2'd0);
    check("rd_idle", resp_ready, 1'b0);
    scan_dmi({7'h10, 32'h0, 2'd0}, dm_out);
    check("rd_capture", dm_out, {7'h10, 32'hDEAD_BEEF, 2'd0});
    check("nop_no_req", req_valid, 1'b0);

    // Write with stalled ready
    scan_dmi({7'h04, 32'h1234_5678, 2'd2}, dm_out);
    for (int k = 0; k < 5; k++) begin
      check("wr_stall", {req_valid, req_op, req_addr, req_data},
            {1'b1, 2'd2, 7'h04, 32'h1234_5678});
      clk_step();
    end
    acc0 = n_acc;
    accept();
    check("wr_one_accept", n_acc, acc0 + 1);
    check("wr_wait", {req_valid, resp_ready}, 2'b01);
    respond(32'h0, 2'd0);
    check("wr_idle", resp_ready, 1'b0);

    // Busy: DMI access while WaitRead
    scan_dmi({7'h20, 32'h0, 2'd1}, dm_out);
    accept();
    acc0 = n_acc;
    scan_dmi({7'h21, 32'h0, 2'd1}, dm_out);
    check("busy_cap_pre", dm_out, {7'h20, 32'h0, 2'd0});
    check("busy_no_req", req_valid, 1'b0);
    check("busy_still_wait", resp_ready, 1'b1);
    respond(32'hCAFE_F00D, 2'd0);
    scan_dmi({7'h30, 32'h0, 2'd1}, dm_out);
    check("busy_cap_post", dm_out, {7'h20, 32'hCAFE_F00D, 2'd3});
    check("busy_blocks_req", req_valid, 1'b0);
    check("busy_acc_count", n_acc, acc0);
    scan_dtmcs(32'h0001_0000, dt_out);
    check("busy_dtmcs", dt_out, 32'h0000_1C71);
    scan_dtmcs(32'h0, dt_out);
    check("dmireset_clears", dt_out, 32'h0000_1071);

    // Recovery after failed response
    scan_dmi({7'h11, 32'h0, 2'd1}, dm_out);
    accept();
    respond(32'h0BAD_F00D, 2'd2);
    scan_dtmcs(32'h0, dt_out);
    check("fail_dtmcs", dt_out, 32'h0000_1871);
    scan_dmi({7'h12, 32'h0, 2'd1}, dm_out);
    check("fail_blocks_req", req_valid, 1'b0);
    scan_dtmcs(32'h0001_0000, dt_out);
    check("fail_sticky", dt_out, 32'h0000_1871);
    scan_dmi({7'h12, 32'h0, 2'd1}, dm_out);
    check("recover_valid", {req_valid, req_addr}, {1'b1, 7'h12});
    accept();
    respond(32'h0, 2'd0);

    // Busy capture coinciding with the response
    scan_dmi({7'h13, 32'h0, 2'd1}, dm_out);
    accept();
    dmi_sel = 1'b1; capture = 1'b1; resp_valid = 1'b1; resp_data = 32'h5555_AAAA;
    clk_step();
    dmi_sel = 1'b0; capture = 1'b0; resp_valid = 1'b0; resp_data = '0;
    check("simul_idle", resp_ready, 1'b0);
    scan_dmi({7'h0, 32'h0, 2'd0}, dm_out);
    check("simul_capture", dm_out, {7'h13, 32'h5555_AAAA, 2'd3});
    scan_dtmcs(32'h0001_0000, dt_out);

    // Hardreset mid-write
    scan_dmi({7'h05, 32'hA5A5_A5A5, 2'd2}, dm_out);
    accept();
    check("hr_wait", resp_ready, 1'b1);
    scan_dtmcs(32'h0002_0000, dt_out);
    check("hr_rst_low", rst_n_out, 1'b0);
    check("hr_idle", {req_valid, resp_ready}, 2'b00);
    clk_step();
    check("hr_rst_high", rst_n_out, 1'b1);
    scan_dtmcs(32'h0, dt_out);
    check("hr_dtmcs", dt_out, 32'h0000_1071);

    // TAP reset clears state and error without a reset pulse
    scan_dmi({7'h33, 32'h0, 2'd1}, dm_out);
    accept();
    scan_dmi({7'h0, 32'h0, 2'd0}, dm_out);
    dmi_clear = 1'b1; clk_step(); dmi_clear = 1'b0;
    check("clr_idle", resp_ready, 1'b0);
    check("clr_no_pulse", rst_n_out, 1'b1);
    scan_dtmcs(32'h0, dt_out);
    check("clr_dtmcs", dt_out, 32'h0000_1071);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
